router_pkt_tx: RTL and testbench
================================

// Module: router_pkt_tx
// PURPOSE
//  Source-side packet transmitter for the 1x3 router. Drives the router input port
//  (data_in/pkt_valid), obeying its busy flow control. Store-and-forward: buffers a
//  whole packet first, so pkt_valid never drops mid-payload. Builds header
//  {len[5:0],addr[1:0]}, payload bytes, then the XOR parity byte.
// PARAMETERS
//  IPG_CYCLES  2   min idle cycles (pkt_valid=0) between parity byte and next header
//  MAX_LEN     63  payload buffer depth in bytes; legal range 1..63
// PORTS
//  clock      in   1  single clock, rising edge
//  resetn     in   1  asynchronous, active-low reset
//  cmd_valid  in   1  packet request valid
//  cmd_ready  out  1  request accepted when cmd_valid&cmd_ready at posedge
//  cmd_addr   in   2  destination port 0..2; 3 is illegal
//  cmd_len    in   6  payload length in bytes, 0..MAX_LEN
//  pl_valid   in   1  payload byte valid
//  pl_ready   out  1  payload byte taken when pl_valid&pl_ready at posedge
//  pl_data    in   8  payload byte
//  busy       in   1  router busy; when 1, the currently driven byte must be held
//  data_out   out  8  byte to router data_in
//  pkt_valid  out  1  1 for header+payload, 0 for parity byte and idle
//  tx_done    out  1  1-cycle pulse on the edge the parity byte is consumed
//  cmd_err    out  1  1-cycle pulse when an illegal request is dropped
//  err_inject in   1  exists only with ROUTER_TX_ERR_INJECT_EN
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; state IDLE; counters 0; buffer contents don't-care.
//  FSM: IDLE -> COLLECT -> ARB -> HEADER -> PAYLOAD -> PARITY -> GAP -> IDLE.
//  IDLE: cmd_ready=1. On accept: addr==3 or len>MAX_LEN -> cmd_err, stay IDLE.
//   Otherwise latch addr/len, parity<=header; len==0 -> ARB, else COLLECT.
//  COLLECT: pl_ready=1. Each accepted byte -> buf[wr_ptr], parity^=byte. Last byte -> ARB.
//  ARB: wait busy==0 (sampled at edge); then load data_out=header, pkt_valid=1 -> HEADER.
//  Consume rule: a driven byte is consumed at a posedge with busy==0. busy==1 -> hold
//   data_out/pkt_valid unchanged, no byte skipped or repeated.
//  HEADER/PAYLOAD consume: load next buf byte (pkt_valid=1). After the last byte (or the
//   header when len==0), load parity with pkt_valid=0 -> PARITY.
//  PARITY consume: data_out=0, pkt_valid=0, tx_done=1, gap_cnt=IPG_CYCLES -> GAP.
//  GAP: count down to 0, then -> IDLE. IPG_CYCLES=0 -> IDLE on the next edge.
//  Latency: len==0, busy=0 -> header 1 cycle after accept. Otherwise header 1 cycle after
//   the last payload byte is accepted.
//  Simultaneous events: cmd_valid is ignored outside IDLE. pl_valid is ignored outside COLLECT.
//  Reset mid-packet clears outputs asynchronously. No partial-packet recovery; the router's
//   own timeout handles it.
//  Parity = header ^ payload[0] ^ ... ^ payload[len-1], 8-bit XOR.
// CONFIGURATION
//  ROUTER_TX_ERR_INJECT_EN defined: err_inject port exists. It is sampled at cmd accept.
//   If 1, the transmitted parity byte is ~parity, to exercise the router's parity-error path.
//  Not defined: port absent; parity is always correct.
// STRUCTURE
//  router_pkg: state enum, HDR_ADDR_LSB/MSB, HDR_LEN_LSB/MSB, ADDR_ILLEGAL=2'b11, BYTE_W=8.
//  Sub-module router_tx_buf: MAX_LEN x 8 regfile, sync write, async read, wr/rd ptr inputs.
//  Top level holds the FSM, length/pointer counters, parity accumulator and gap counter.
// TESTING
//  1 addr=1 len=3 pl=A1,B2,C3, busy=0 -> 0D,A1,B2,C3 with pkt_valid=1, then DD with
//    pkt_valid=0; tx_done pulses once.
//  2 Same packet, busy=1 for 2 cycles while B2 driven -> B2 held 3 cycles; sequence and
//    parity unchanged.
//  3 addr=2 len=0 -> header 02 (pkt_valid=1), then parity 02 (pkt_valid=0); pl_ready never 1.
//  4 addr=3 len=5 -> cmd_err 1 cycle; pkt_valid stays 0; cmd_ready=1 next cycle.
//  5 resetn=0 mid-PAYLOAD -> pkt_valid=0, data_out=0 immediately; after release cmd_ready=1,
//    then a fresh packet is correct.
//  6 Back-to-back cmds, IPG_CYCLES=2 -> at least 2 idle cycles between parity and next header.
//    With macro + err_inject=1 on test 1 -> parity byte 22.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and header layout for the 1x3 router packet transmitter.
// ROUTER_TX_ERR_INJECT_EN adds a parity-corruption hook to the interface.
package router_pkg;

  localparam int BYTE_W       = 8;
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;
  localparam int LEN_W        = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  localparam logic [1:0] ADDR_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_ARB     = 3'd2,
    ST_HEADER  = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_PARITY  = 3'd5,
    ST_GAP     = 3'd6
  } state_t;

  function automatic logic [BYTE_W-1:0] mk_hdr(
    input logic [LEN_W-1:0] len,
    input logic [1:0]       addr
  );
    logic [BYTE_W-1:0] h;
    h = '0;
    h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
    h[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
    return h;
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Request, payload and router-side signals of the packet transmitter.
// ROUTER_TX_ERR_INJECT_EN adds err_inject to both modports.
interface router_pkt_tx_if;
  import router_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              pl_valid;
  logic              pl_ready;
  logic [BYTE_W-1:0] pl_data;
  logic              busy;
  logic [BYTE_W-1:0] data_out;
  logic              pkt_valid;
  logic              tx_done;
  logic              cmd_err;

`ifdef ROUTER_TX_ERR_INJECT_EN
  logic              err_inject;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, pl_valid, pl_data,
    output busy, err_inject,
    input  cmd_ready, pl_ready, data_out, pkt_valid,
    input  tx_done, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, pl_valid, pl_data,
    input  busy, err_inject,
    output cmd_ready, pl_ready, data_out, pkt_valid,
    output tx_done, cmd_err
  );
`else
  modport master (
    output cmd_valid, cmd_addr, cmd_len, pl_valid, pl_data,
    output busy,
    input  cmd_ready, pl_ready, data_out, pkt_valid,
    input  tx_done, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, pl_valid, pl_data,
    input  busy,
    output cmd_ready, pl_ready, data_out, pkt_valid,
    output tx_done, cmd_err
  );
`endif

endinterface

// File: rtl/router_tx_buf.sv
// Payload store for one packet: synchronous write, asynchronous read.
// Contents are never reset; only bytes written for the current packet are read.
module router_tx_buf
  import router_pkg::*;
#(
  parameter int DEPTH = 63
) (
  input  logic              clock,
  input  logic              we,
  input  logic [LEN_W-1:0]  wr_ptr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic [LEN_W-1:0]  rd_ptr,
  output logic [BYTE_W-1:0] rd_data
);

  logic [BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/router_pkt_tx.sv
// Store-and-forward packet source for the 1x3 router input port.
// ROUTER_TX_ERR_INJECT_EN enables err_inject (inverted parity byte).
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int IPG_CYCLES = 2,
  parameter int MAX_LEN    = 63
) (
  input logic            clock,
  input logic            resetn,
  router_pkt_tx_if.slave bus
);

  state_t            state;
  logic [1:0]        addr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  wr_ptr;
  logic [LEN_W-1:0]  rd_ptr;
  logic [BYTE_W-1:0] parity;
  logic [BYTE_W-1:0] rd_data;
  logic [BYTE_W-1:0] par_out;
  logic [7:0]        gap_cnt;
  logic              inject;
  logic              cmd_acc;
  logic              pl_acc;
  logic              cmd_bad;
  logic              last_wr;
  logic              sent_all;

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.pl_ready  = (state == ST_COLLECT);
  assign cmd_acc  = bus.cmd_valid & bus.cmd_ready;
  assign pl_acc   = bus.pl_valid & bus.pl_ready;
  assign cmd_bad  = (bus.cmd_addr == ADDR_ILLEGAL) ||
                    (bus.cmd_len > LEN_W'(MAX_LEN));
  assign last_wr  = (wr_ptr == len - LEN_W'(1));
  assign sent_all = (rd_ptr == len);
  assign par_out  = inject ? ~parity : parity;

`ifdef ROUTER_TX_ERR_INJECT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) inject <= 1'b0;
    else if (cmd_acc && !cmd_bad) inject <= bus.err_inject;
  end
`else
  assign inject = 1'b0;
`endif

  router_tx_buf #(
    .DEPTH   (MAX_LEN)
  ) u_buf (
    .clock   (clock),
    .we      (pl_acc),
    .wr_ptr  (wr_ptr),
    .wr_data (bus.pl_data),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      addr          <= '0;
      len           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      parity        <= '0;
      gap_cnt       <= '0;
      bus.data_out  <= '0;
      bus.pkt_valid <= 1'b0;
      bus.tx_done   <= 1'b0;
      bus.cmd_err   <= 1'b0;
    end else begin
      bus.tx_done <= 1'b0;
      bus.cmd_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_acc && cmd_bad) begin
            bus.cmd_err <= 1'b1;
          end else if (cmd_acc) begin
            addr   <= bus.cmd_addr;
            len    <= bus.cmd_len;
            parity <= mk_hdr(bus.cmd_len, bus.cmd_addr);
            wr_ptr <= '0;
            state  <= (bus.cmd_len == '0) ? ST_ARB : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (pl_acc) begin
            parity <= parity ^ bus.pl_data;
            wr_ptr <= wr_ptr + LEN_W'(1);
            if (last_wr) state <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (!bus.busy) begin
            bus.data_out  <= mk_hdr(len, addr);
            bus.pkt_valid <= 1'b1;
            rd_ptr        <= '0;
            state         <= ST_HEADER;
          end
        end
        // rd_ptr counts bytes already sent after the header
        ST_HEADER, ST_PAYLOAD: begin
          if (!bus.busy && sent_all) begin
            bus.data_out  <= par_out;
            bus.pkt_valid <= 1'b0;
            state         <= ST_PARITY;
          end else if (!bus.busy) begin
            bus.data_out <= rd_data;
            rd_ptr       <= rd_ptr + LEN_W'(1);
            state        <= ST_PAYLOAD;
          end
        end
        ST_PARITY: begin
          if (!bus.busy) begin
            bus.data_out <= '0;
            bus.tx_done  <= 1'b1;
            gap_cnt      <= 8'(IPG_CYCLES);
            state        <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= ST_IDLE;
          else gap_cnt <= gap_cnt - 8'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: table rows, corner sequences, random packets.
// Build with ROUTER_TX_ERR_INJECT_EN to cover the inverted-parity path.
module tb_router_pkt_tx;
  import router_pkg::*;

  typedef struct {
    logic [1:0]       a;
    logic [LEN_W-1:0] l;
    int               bpct;
    int               hold;
    int               abort;
    bit               inj;
    bit               fixed;
    logic [7:0]       hdr;
    logic [7:0]       par;
  } vec_t;

`ifdef ROUTER_TX_ERR_INJECT_EN
  localparam bit         INJ_EN     = 1'b1;
  localparam logic [7:0] T1_INJ_PAR = 8'h22;
`else
  localparam bit         INJ_EN     = 1'b0;
  localparam logic [7:0] T1_INJ_PAR = 8'hDD;
`endif

  logic clock  = 1'b0;
  logic resetn = 1'b1;
  int   vecs = 0;
  int   errs = 0;
  int   cyc = 0;
  int   last_par = -1;
  logic [7:0] fix_pl [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  vec_t tbl [$];

  router_pkt_tx_if bus ();

  router_pkt_tx #(
    .IPG_CYCLES (2),
    .MAX_LEN    (63)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vecs++;
    errs++;
    $display("FAIL %s: got timeout expected progress", name);
  endtask

  function automatic logic pick(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic run_pkt(input vec_t v);
    logic [7:0] pl [$];
    logic [7:0] eb [$];
    logic       ev [$];
    logic [7:0] par;
    int n, idx, held;
    bit acc, go;
    for (int i = 0; i < int'(v.l); i++)
      pl.push_back(v.fixed ? fix_pl[i % 4] : 8'($urandom));
    par = {v.l, v.a};
    eb.push_back(v.fixed ? v.hdr : {v.l, v.a});
    ev.push_back(1'b1);
    foreach (pl[i]) begin
      par ^= pl[i];
      eb.push_back(pl[i]);
      ev.push_back(1'b1);
    end
    if (INJ_EN && v.inj) par = ~par;
    eb.push_back(v.fixed ? v.par : par);
    ev.push_back(1'b0);

    @(negedge clock);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = v.a;
    bus.cmd_len   = v.l;
`ifdef ROUTER_TX_ERR_INJECT_EN
    bus.err_inject = v.inj;
`endif
    n = 0;
    do begin
      acc = bus.cmd_ready;
      @(negedge clock);
      n++;
    end while (!acc && n < 100);
    bus.cmd_valid = 1'b0;
    if (!acc) begin
      timeout("cmd_accept");
      return;
    end
    if (v.a == 2'd3) begin
      chk("cmd_err_pulse", bus.cmd_err, 1);
      chk("err_pkt_valid", bus.pkt_valid, 0);
      @(negedge clock);
      chk("cmd_err_clear", bus.cmd_err, 0);
      chk("err_cmd_ready", bus.cmd_ready, 1);
      return;
    end
    chk("cmd_err_quiet", bus.cmd_err, 0);
    if (v.l == '0) chk("pl_ready_len0", bus.pl_ready, 0);

    idx = 0;
    n = 0;
    while (idx < int'(v.l) && n < 1000) begin
      bus.pl_valid = pick(75);
      bus.pl_data  = pl[idx];
      go = bus.pl_valid && bus.pl_ready;
      @(negedge clock);
      n++;
      if (go) idx++;
    end
    bus.pl_valid = 1'b0;
    if (idx < int'(v.l)) begin
      timeout("payload_accept");
      return;
    end

    n = 0;
    while (!bus.pkt_valid && n < 200) begin
      bus.busy = pick(v.bpct);
      @(negedge clock);
      n++;
    end
    if (!bus.pkt_valid) begin
      bus.busy = 1'b0;
      timeout("header_start");
      return;
    end
    if (v.bpct == 0) chk("hdr_latency", n, 1);
    if (last_par >= 0) chk("ipg_idle_ok", (cyc - last_par) >= 2, 1);

    idx = 0;
    held = 0;
    n = 0;
    while (idx < eb.size() && n < 2000) begin
      chk($sformatf("byte%0d_data", idx), bus.data_out, eb[idx]);
      chk($sformatf("byte%0d_valid", idx), bus.pkt_valid, ev[idx]);
      chk("tx_done_early", bus.tx_done, 0);
      if (idx == v.abort) begin
        bus.busy = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("rst_pkt_valid", bus.pkt_valid, 0);
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        @(negedge clock);
        resetn = 1'b1;
        last_par = -1;
        @(negedge clock);
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);
        return;
      end
      if (idx == v.hold && held < 2) begin
        bus.busy = 1'b1;
        held++;
      end else begin
        bus.busy = pick(v.bpct);
      end
      if (!bus.busy) begin
        idx++;
        if (idx == eb.size()) last_par = cyc + 1;
      end
      @(negedge clock);
      n++;
    end
    bus.busy = 1'b0;
    if (idx < eb.size()) begin
      timeout("transmit");
      return;
    end
    chk("tx_done_pulse", bus.tx_done, 1);
    chk("idle_data_out", bus.data_out, 0);
    chk("idle_pkt_valid", bus.pkt_valid, 0);
    @(negedge clock);
    chk("tx_done_single", bus.tx_done, 0);
  endtask

  initial begin
    vec_t v;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.pl_valid  = 1'b0;
    bus.pl_data   = '0;
    bus.busy      = 1'b0;
`ifdef ROUTER_TX_ERR_INJECT_EN
    bus.err_inject = 1'b0;
`endif
    #1 resetn = 1'b0;
    #2;
    chk("reset_cmd_ready", bus.cmd_ready, 1);
    chk("reset_pl_ready", bus.pl_ready, 0);
    chk("reset_pkt_valid", bus.pkt_valid, 0);
    chk("reset_data_out", bus.data_out, 0);
    chk("reset_tx_done", bus.tx_done, 0);
    chk("reset_cmd_err", bus.cmd_err, 0);
    @(negedge clock);
    resetn = 1'b1;

    tbl.push_back('{2'd1, 6'd3, 0, -1, -1, 1'b0, 1'b1, 8'h0D, 8'hDD});
    tbl.push_back('{2'd1, 6'd3, 0, 2, -1, 1'b0, 1'b1, 8'h0D, 8'hDD});
    tbl.push_back('{2'd2, 6'd0, 0, -1, -1, 1'b0, 1'b1, 8'h02, 8'h02});
    tbl.push_back('{2'd3, 6'd5, 0, -1, -1, 1'b0, 1'b0, 8'h00, 8'h00});
    tbl.push_back('{2'd0, 6'd4, 0, -1, 2, 1'b0, 1'b0, 8'h00, 8'h00});
    tbl.push_back('{2'd1, 6'd3, 0, -1, -1, 1'b0, 1'b1, 8'h0D, 8'hDD});
    tbl.push_back('{2'd1, 6'd3, 0, -1, -1, 1'b1, 1'b1, 8'h0D, T1_INJ_PAR});
    tbl.push_back('{2'd0, 6'd63, 20, -1, -1, 1'b0, 1'b0, 8'h00, 8'h00});
    tbl.push_back('{2'd2, 6'd1, 0, -1, -1, 1'b0, 1'b0, 8'h00, 8'h00});
    tbl.push_back('{2'd3, 6'd0, 0, -1, -1, 1'b0, 1'b0, 8'h00, 8'h00});
    foreach (tbl[i]) run_pkt(tbl[i]);

    for (int k = 0; k < 40; k++) begin
      v.a     = 2'($urandom_range(0, 3));
      v.l     = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                            : 6'($urandom_range(0, 8));
      v.bpct  = int'($urandom_range(0, 50));
      v.hold  = -1;
      v.abort = -1;
      v.inj   = 1'($urandom_range(0, 1));
      v.fixed = 1'b0;
      v.hdr   = '0;
      v.par   = '0;
      run_pkt(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
